// File: rtl/ahb_matrix_input_stage_v2.sv
// Master-side AHB-Lite matrix input stage: holds an address phase the decoder cannot take yet,
// presents live or held phase downstream, and optionally aborts long waits with a 2-cycle ERROR.
module ahb_matrix_input_stage_v2 #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic                  HMASTLOCK,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HREADY,
    input  logic                  ACTIVE_Decoder,
    input  logic                  HREADYOUT_Decoder,
    input  logic [1:0]            HRESP_Decoder,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [ADDR_WIDTH-1:0] HADDR_Inputstage,
    output logic [1:0]            HTRANS_Inputstage,
    output logic                  HWRITE_Inputstage,
    output logic                  HMASTLOCK_Inputstage,
    output logic [2:0]            HSIZE_Inputstage,
    output logic [2:0]            HBURST_Inputstage,
    output logic [3:0]            HPROT_Inputstage,
    output logic                  TRANS_HOLD,
    output logic                  TIMEOUT_EVT
);

    typedef enum logic [2:0] {
        StIdle,
        StFwd,
        StPend,
        StErr1,
        StErr2
    } state_e;

    localparam logic [1:0] RespOkay  = 2'b00;
    localparam logic [1:0] RespError = 2'b01;

    state_e r_state;
    state_e w_state_next;
    state_e w_sample_state;

    logic w_valid;
    logic w_grant;
    logic w_timeout;

    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [1:0]            r_htrans;
    logic                  r_hwrite;
    logic                  r_hmastlock;
    logic [2:0]            r_hsize;
    logic [2:0]            r_hburst;
    logic [3:0]            r_hprot;

    assign w_valid = HTRANS[1] & HREADY;
    assign w_grant = ACTIVE_Decoder & HREADYOUT_Decoder;

    // Every sampled NONSEQ/SEQ is captured, so a later PEND always presents the latest phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_haddr     <= '0;
            r_htrans    <= 2'b00;
            r_hwrite    <= 1'b0;
            r_hmastlock <= 1'b0;
            r_hsize     <= 3'b000;
            r_hburst    <= 3'b000;
            r_hprot     <= 4'b0000;
        end else if (w_valid) begin
            r_haddr     <= HADDR;
            r_htrans    <= HTRANS;
            r_hwrite    <= HWRITE;
            r_hmastlock <= HMASTLOCK;
            r_hsize     <= HSIZE;
            r_hburst    <= HBURST;
            r_hprot     <= HPROT;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int unsigned CntW = $clog2(TIMEOUT + 1);

            logic [CntW-1:0] r_wait_cnt;
            logic [CntW-1:0] w_wait_cnt_next;

            // Only ungranted PEND cycles count; a grant with wait states restarts the window.
            always_comb begin
                w_wait_cnt_next = '0;
                if (r_state == StPend && !ACTIVE_Decoder) begin
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                end
            end

            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    r_wait_cnt <= '0;
                end else begin
                    r_wait_cnt <= w_wait_cnt_next;
                end
            end

            assign w_timeout = (r_state == StPend) && !ACTIVE_Decoder &&
                               (r_wait_cnt == CntW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        w_sample_state = StIdle;
        if (w_valid) begin
            w_sample_state = ACTIVE_Decoder ? StFwd : StPend;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StErr2: w_state_next = w_sample_state;
            StFwd: begin
                if (HREADY) begin
                    w_state_next = w_sample_state;
                end
            end
            StPend: begin
                // Grant is checked first so a grant on the last count never errors.
                if (w_grant) begin
                    w_state_next = StFwd;
                end else if (w_timeout) begin
                    w_state_next = StErr1;
                end
            end
            StErr1:  w_state_next = StErr2;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        HADDR_Inputstage     = HADDR;
        HTRANS_Inputstage    = HTRANS;
        HWRITE_Inputstage    = HWRITE;
        HMASTLOCK_Inputstage = HMASTLOCK;
        HSIZE_Inputstage     = HSIZE;
        HBURST_Inputstage    = HBURST;
        HPROT_Inputstage     = HPROT;
        if (r_state == StPend || r_state == StErr1 || r_state == StErr2) begin
            HADDR_Inputstage     = r_haddr;
            HTRANS_Inputstage    = (r_state == StPend) ? r_htrans : 2'b00;
            HWRITE_Inputstage    = r_hwrite;
            HMASTLOCK_Inputstage = r_hmastlock;
            HSIZE_Inputstage     = r_hsize;
            HBURST_Inputstage    = r_hburst;
            HPROT_Inputstage     = r_hprot;
        end
    end

    always_comb begin
        HREADYOUT   = 1'b1;
        HRESP       = RespOkay;
        TIMEOUT_EVT = 1'b0;
        unique case (r_state)
            StIdle: begin
                HREADYOUT = 1'b1;
                HRESP     = RespOkay;
            end
            StFwd: begin
                HREADYOUT = HREADYOUT_Decoder;
                HRESP     = HRESP_Decoder;
            end
            StPend: begin
                HREADYOUT = 1'b0;
                HRESP     = RespOkay;
            end
            StErr1: begin
                HREADYOUT   = 1'b0;
                HRESP       = RespError;
                TIMEOUT_EVT = 1'b1;
            end
            StErr2: begin
                HREADYOUT = 1'b1;
                HRESP     = RespError;
            end
            default: begin
                HREADYOUT = 1'b1;
                HRESP     = RespOkay;
            end
        endcase
    end

    assign TRANS_HOLD = w_valid | (r_state == StPend);

endmodule

// File: tb/tb_ahb_matrix_input_stage_v2.sv
// Bench for ahb_matrix_input_stage_v2: directed vector table, hand-written reset/width
// sequences, then randomized stimulus against a behavioural model.
module tb_ahb_matrix_input_stage_v2;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] HADDR = '0;
    logic [19:0] HADDR2 = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic        HMASTLOCK = 1'b0;
    logic [2:0]  HSIZE = 3'd2;
    logic [2:0]  HBURST = 3'd0;
    logic [3:0]  HPROT = 4'd3;
    logic        HREADY = 1'b1;
    logic        ACTIVE_Decoder = 1'b0;
    logic        HREADYOUT_Decoder = 1'b1;
    logic [1:0]  HRESP_Decoder = 2'b00;

    logic        d1_rdy, d1_write, d1_lock, d1_hold, d1_evt;
    logic [1:0]  d1_resp, d1_trans;
    logic [31:0] d1_addr;
    logic [2:0]  d1_size, d1_burst;
    logic [3:0]  d1_prot;

    logic        d2_rdy, d2_write, d2_lock, d2_hold, d2_evt;
    logic [1:0]  d2_resp, d2_trans;
    logic [19:0] d2_addr;
    logic [2:0]  d2_size, d2_burst;
    logic [3:0]  d2_prot;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    ahb_matrix_input_stage_v2 #(.ADDR_WIDTH(32), .TIMEOUT(4)) u_dut_t4 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HMASTLOCK(HMASTLOCK), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HREADY(HREADY), .ACTIVE_Decoder(ACTIVE_Decoder),
        .HREADYOUT_Decoder(HREADYOUT_Decoder), .HRESP_Decoder(HRESP_Decoder),
        .HREADYOUT(d1_rdy), .HRESP(d1_resp), .HADDR_Inputstage(d1_addr),
        .HTRANS_Inputstage(d1_trans), .HWRITE_Inputstage(d1_write),
        .HMASTLOCK_Inputstage(d1_lock), .HSIZE_Inputstage(d1_size),
        .HBURST_Inputstage(d1_burst), .HPROT_Inputstage(d1_prot),
        .TRANS_HOLD(d1_hold), .TIMEOUT_EVT(d1_evt)
    );

    ahb_matrix_input_stage_v2 #(.ADDR_WIDTH(20), .TIMEOUT(0)) u_dut_a20 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR2), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HMASTLOCK(HMASTLOCK), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HREADY(HREADY), .ACTIVE_Decoder(ACTIVE_Decoder),
        .HREADYOUT_Decoder(HREADYOUT_Decoder), .HRESP_Decoder(HRESP_Decoder),
        .HREADYOUT(d2_rdy), .HRESP(d2_resp), .HADDR_Inputstage(d2_addr),
        .HTRANS_Inputstage(d2_trans), .HWRITE_Inputstage(d2_write),
        .HMASTLOCK_Inputstage(d2_lock), .HSIZE_Inputstage(d2_size),
        .HBURST_Inputstage(d2_burst), .HPROT_Inputstage(d2_prot),
        .TRANS_HOLD(d2_hold), .TIMEOUT_EVT(d2_evt)
    );

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write, lock, ready, act, rdyd;
        logic [1:0]  respd;
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic [31:0] e_addr;
        logic        e_write, e_lock;
        logic [1:0]  e_trans;
        logic        e_hold, e_evt;
    } vec_t;

    typedef struct {
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write, lock;
        logic [2:0]  size, burst;
        logic [3:0]  prot;
        logic        hold, evt;
    } exp_t;

    // Abstract model: "what is the master waiting for", not a state encoding.
    typedef struct {
        bit          pend;      // address phase held, not yet accepted
        bit          fwd;       // data phase owned by a slave
        int          err;       // 0 none, 1/2 = first/second ERROR cycle
        int          wt;        // ungranted pending cycles so far
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write, lock;
        logic [2:0]  size, burst;
        logic [3:0]  prot;
    } mdl_t;

    vec_t vecs[$];
    mdl_t m1, m2;

    function automatic vec_t mk(input logic [1:0] trans, input logic [31:0] addr,
                                input logic write, input logic lock, input logic ready,
                                input logic act, input logic rdyd, input logic [1:0] respd,
                                input logic e_rdy, input logic [1:0] e_resp,
                                input logic [31:0] e_addr, input logic e_write,
                                input logic e_lock, input logic [1:0] e_trans,
                                input logic e_hold, input logic e_evt);
        vec_t v;
        v.trans = trans; v.addr = addr; v.write = write; v.lock = lock; v.ready = ready;
        v.act = act; v.rdyd = rdyd; v.respd = respd;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_addr = e_addr; v.e_write = e_write;
        v.e_lock = e_lock; v.e_trans = e_trans; v.e_hold = e_hold; v.e_evt = e_evt;
        return v;
    endfunction

    function automatic mdl_t m_reset();
        mdl_t s;
        s.pend = 0; s.fwd = 0; s.err = 0; s.wt = 0;
        s.addr = '0; s.trans = '0; s.write = 0; s.lock = 0;
        s.size = '0; s.burst = '0; s.prot = '0;
        return s;
    endfunction

    function automatic exp_t m_expect(input mdl_t s);
        exp_t e;
        logic valid;
        valid   = HTRANS[1] & HREADY;
        e.addr  = HADDR;  e.trans = HTRANS; e.write = HWRITE; e.lock = HMASTLOCK;
        e.size  = HSIZE;  e.burst = HBURST; e.prot = HPROT;
        if (s.pend || s.err != 0) begin
            e.addr  = s.addr;  e.trans = (s.err != 0) ? 2'b00 : s.trans;
            e.write = s.write; e.lock = s.lock; e.size = s.size; e.burst = s.burst;
            e.prot  = s.prot;
        end
        e.hold = valid | s.pend;
        e.evt  = (s.err == 1);
        if (s.err == 1)      begin e.rdy = 0; e.resp = 2'b01; end
        else if (s.err == 2) begin e.rdy = 1; e.resp = 2'b01; end
        else if (s.pend)     begin e.rdy = 0; e.resp = 2'b00; end
        else if (s.fwd)      begin e.rdy = HREADYOUT_Decoder; e.resp = HRESP_Decoder; end
        else                 begin e.rdy = 1; e.resp = 2'b00; end
        return e;
    endfunction

    function automatic mdl_t m_next(input mdl_t s, input int tmo);
        mdl_t n;
        logic valid;
        n     = s;
        valid = HTRANS[1] & HREADY;
        n.wt  = (s.pend && !ACTIVE_Decoder) ? s.wt + 1 : 0;
        if (valid) begin
            n.addr = HADDR; n.trans = HTRANS; n.write = HWRITE; n.lock = HMASTLOCK;
            n.size = HSIZE; n.burst = HBURST; n.prot = HPROT;
        end
        if (s.err == 1) begin
            n.err = 2;
        end else if (s.pend) begin
            if (ACTIVE_Decoder && HREADYOUT_Decoder) begin
                n.pend = 0; n.fwd = 1;
            end else if (tmo > 0 && !ACTIVE_Decoder && s.wt == tmo - 1) begin
                n.pend = 0; n.err = 1;
            end
        end else if (!(s.fwd && !HREADY)) begin
            n.err  = 0;
            n.fwd  = valid && ACTIVE_Decoder;
            n.pend = valid && !ACTIVE_Decoder;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        HTRANS = 2'b00; HREADY = 1'b1; ACTIVE_Decoder = 1'b0;
        HREADYOUT_Decoder = 1'b1; HRESP_Decoder = 2'b00;
        step();
        step();
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();
    endtask

    initial begin
        // Directed table: same-cycle grant, delayed grant, timeout, ERR2 resample,
        // slave ERROR and locked burst, BUSY.
        vecs.push_back(mk(2, 32'h2000_0000, 0, 0, 1, 1, 1, 0, 1, 0, 32'h2000_0000, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 32'h4000_0010, 1, 0, 1, 0, 1, 0, 1, 0, 32'h4000_0010, 1, 0, 2, 1, 0));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(2, 32'hDEAD_0000, 0, 0, 0, 0, 1, 0,
                              0, 0, 32'h4000_0010, 1, 0, 2, 1, 0));
        end
        vecs.push_back(mk(2, 32'hDEAD_0000, 0, 0, 0, 1, 1, 0, 0, 0, 32'h4000_0010, 1, 0, 2, 1, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 32'h6000_0000, 0, 0, 1, 0, 1, 0, 1, 0, 32'h6000_0000, 0, 0, 2, 1, 0));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(2, 32'h6000_0000, 0, 0, 0, 0, 1, 0,
                              0, 0, 32'h6000_0000, 0, 0, 2, 1, 0));
        end
        vecs.push_back(mk(2, 32'h6000_0000, 0, 0, 0, 0, 1, 0, 0, 1, 32'h6000_0000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(2, 32'h7000_0000, 0, 0, 1, 1, 1, 0, 1, 1, 32'h6000_0000, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 32'h8000_0000, 0, 1, 1, 1, 1, 0, 1, 0, 32'h8000_0000, 0, 1, 2, 1, 0));
        vecs.push_back(mk(3, 32'h8000_0004, 0, 1, 0, 1, 0, 1, 0, 1, 32'h8000_0004, 0, 1, 3, 0, 0));
        vecs.push_back(mk(3, 32'h8000_0004, 0, 1, 1, 1, 1, 1, 1, 1, 32'h8000_0004, 0, 1, 3, 1, 0));
        vecs.push_back(mk(3, 32'h8000_0008, 0, 1, 1, 1, 1, 0, 1, 0, 32'h8000_0008, 0, 1, 3, 1, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h9000_0000, 0, 0, 1, 0, 1, 0, 1, 0, 32'h9000_0000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h9000_0000, 0, 0, 1, 0, 1, 0, 1, 0, 32'h9000_0000, 0, 0, 1, 0, 0));

        // Reset state: outputs quiescent, decoder side follows live inputs.
        HADDR = 32'h1234_5678;
        #2;
        chk("reset hreadyout", 32'(d1_rdy), 32'd1);
        chk("reset hresp", 32'(d1_resp), 32'd0);
        chk("reset timeout_evt", 32'(d1_evt), 32'd0);
        chk("reset trans_hold", 32'(d1_hold), 32'd0);
        chk("reset haddr live", d1_addr, 32'h1234_5678);
        do_reset();

        foreach (vecs[i]) begin
            HTRANS = vecs[i].trans; HADDR = vecs[i].addr; HWRITE = vecs[i].write;
            HMASTLOCK = vecs[i].lock; HREADY = vecs[i].ready;
            ACTIVE_Decoder = vecs[i].act; HREADYOUT_Decoder = vecs[i].rdyd;
            HRESP_Decoder = vecs[i].respd;
            @(negedge HCLK);
            chk($sformatf("vec%0d hreadyout", i), 32'(d1_rdy), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d hresp", i), 32'(d1_resp), 32'(vecs[i].e_resp));
            chk($sformatf("vec%0d haddr", i), d1_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d hwrite", i), 32'(d1_write), 32'(vecs[i].e_write));
            chk($sformatf("vec%0d hmastlock", i), 32'(d1_lock), 32'(vecs[i].e_lock));
            chk($sformatf("vec%0d htrans", i), 32'(d1_trans), 32'(vecs[i].e_trans));
            chk($sformatf("vec%0d trans_hold", i), 32'(d1_hold), 32'(vecs[i].e_hold));
            chk($sformatf("vec%0d timeout_evt", i), 32'(d1_evt), 32'(vecs[i].e_evt));
            step();
        end

        // Reset asserted while a transfer is pending drops it immediately.
        HTRANS = 2'b10; HADDR = 32'hA000_0000; HREADY = 1'b1; ACTIVE_Decoder = 1'b0;
        step();
        HREADY = 1'b0;
        @(negedge HCLK);
        chk("pend before reset hreadyout", 32'(d1_rdy), 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("async reset hreadyout", 32'(d1_rdy), 32'd1);
        chk("async reset hresp", 32'(d1_resp), 32'd0);
        chk("async reset trans_hold", 32'(d1_hold), 32'd0);
        chk("async reset timeout_evt", 32'(d1_evt), 32'd0);
        do_reset();

        // 20-bit instance: full-width address forwarded and held; no timeout logic.
        HADDR2 = 20'hFFFFF; HTRANS = 2'b10; HREADY = 1'b1; ACTIVE_Decoder = 1'b0;
        @(negedge HCLK);
        chk("a20 live haddr", 32'(d2_addr), 32'h000F_FFFF);
        step();
        HADDR2 = 20'h00000; HREADY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge HCLK);
            chk($sformatf("a20 held haddr c%0d", i), 32'(d2_addr), 32'h000F_FFFF);
            chk($sformatf("a20 hreadyout c%0d", i), 32'(d2_rdy), 32'd0);
            chk($sformatf("a20 timeout_evt c%0d", i), 32'(d2_evt), 32'd0);
            step();
        end
        do_reset();

        // Randomized run against the behavioural model.
        m1 = m_reset();
        m2 = m_reset();
        for (int c = 0; c < 3000; c++) begin
            exp_t e1, e2;
            HTRANS = 2'($urandom_range(0, 3));
            HADDR = $urandom();
            HADDR2 = HADDR[19:0];
            HWRITE = 1'($urandom_range(0, 1));
            HMASTLOCK = 1'($urandom_range(0, 1));
            HSIZE = 3'($urandom_range(0, 7));
            HBURST = 3'($urandom_range(0, 7));
            HPROT = 4'($urandom_range(0, 15));
            HREADY = ($urandom_range(0, 3) != 0);
            ACTIVE_Decoder = ($urandom_range(0, 2) == 0);
            HREADYOUT_Decoder = ($urandom_range(0, 3) != 0);
            HRESP_Decoder = {1'b0, 1'($urandom_range(0, 1))};
            @(negedge HCLK);
            e1 = m_expect(m1);
            e2 = m_expect(m2);
            chk($sformatf("rnd%0d hreadyout", c), 32'(d1_rdy), 32'(e1.rdy));
            chk($sformatf("rnd%0d hresp", c), 32'(d1_resp), 32'(e1.resp));
            chk($sformatf("rnd%0d haddr", c), d1_addr, e1.addr);
            chk($sformatf("rnd%0d htrans", c), 32'(d1_trans), 32'(e1.trans));
            chk($sformatf("rnd%0d hwrite", c), 32'(d1_write), 32'(e1.write));
            chk($sformatf("rnd%0d hmastlock", c), 32'(d1_lock), 32'(e1.lock));
            chk($sformatf("rnd%0d hsize", c), 32'(d1_size), 32'(e1.size));
            chk($sformatf("rnd%0d hburst", c), 32'(d1_burst), 32'(e1.burst));
            chk($sformatf("rnd%0d hprot", c), 32'(d1_prot), 32'(e1.prot));
            chk($sformatf("rnd%0d trans_hold", c), 32'(d1_hold), 32'(e1.hold));
            chk($sformatf("rnd%0d timeout_evt", c), 32'(d1_evt), 32'(e1.evt));
            chk($sformatf("rnd%0d a20 hreadyout", c), 32'(d2_rdy), 32'(e2.rdy));
            chk($sformatf("rnd%0d a20 hresp", c), 32'(d2_resp), 32'(e2.resp));
            chk($sformatf("rnd%0d a20 haddr", c), 32'(d2_addr), 32'(e2.addr[19:0]));
            chk($sformatf("rnd%0d a20 timeout_evt", c), 32'(d2_evt), 32'(e2.evt));
            m1 = m_next(m1, 4);
            m2 = m_next(m2, 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
